// File: rtl/debug_scan_host.sv
// Debug-port host: single-steps the core, then sweeps every debug slot into a snapshot buffer.
// Latency: a step takes STEP_HIGH+SETTLE+NUM_ADDR+CAPTURE_LAT cycles; a snapshot takes NUM_ADDR+CAPTURE_LAT; reads take 1 cycle.
// Backpressure: none; requests that arrive while busy are dropped, not queued.
module debug_scan_host #(
    parameter int NUM_ADDR    = 32,
    parameter int STEP_HIGH   = 4,
    parameter int SETTLE      = 4,
    parameter int CAPTURE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_step,
    input  logic        step_req,
    input  logic        snap_req,
    output logic        debug_en,
    output logic        debug_step,
    output logic [6:0]  debug_addr,
    input  logic [31:0] debug_data,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        snap_valid,
    output logic [15:0] step_count
);

    typedef enum logic [2:0] {IDLE, STEP_HI, STEP_LO, SCAN, DRAIN} state_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] addr;
    } capTag_t;

    localparam logic [4:0] LAST_ADDR   = 5'(NUM_ADDR - 1);
    localparam logic [7:0] STEP_LAST   = 8'(STEP_HIGH - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0] DRAIN_LAST  = 8'(CAPTURE_LAT - 1);

    state_t      state, stateNext;
    logic [7:0]  cnt;
    logic [4:0]  scanAddr, scanAddrNext;
    capTag_t     capPipe [CAPTURE_LAT];
    logic [31:0] snapBuf [32];

    assign debug_addr = {2'b00, scanAddr};
    assign busy       = (state != IDLE);

    always_comb begin
        stateNext    = state;
        scanAddrNext = scanAddr;
        case (state)
            IDLE: begin
                // A step's own scan also serves a simultaneous snapshot request.
                if (step_req && debug_en) begin
                    stateNext = STEP_HI;
                end else if (snap_req) begin
                    stateNext    = SCAN;
                    scanAddrNext = 5'd0;
                end
            end
            STEP_HI: begin
                if (cnt == STEP_LAST) stateNext = STEP_LO;
            end
            STEP_LO: begin
                if (cnt == SETTLE_LAST) begin
                    stateNext    = SCAN;
                    scanAddrNext = 5'd0;
                end
            end
            SCAN: begin
                if (scanAddr == LAST_ADDR) stateNext = DRAIN;
                else                       scanAddrNext = scanAddr + 5'd1;
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    stateNext    = IDLE;
                    scanAddrNext = 5'd0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            scanAddr   <= 5'd0;
            debug_en   <= 1'b0;
            debug_step <= 1'b0;
            step_count <= 16'd0;
            snap_valid <= 1'b0;
            rd_data    <= 32'd0;
            for (int i = 0; i < CAPTURE_LAT; i++) capPipe[i] <= '0;
        end else begin
            state      <= stateNext;
            cnt        <= (stateNext != state) ? 8'd0 : cnt + 8'd1;
            scanAddr   <= scanAddrNext;
            debug_step <= (stateNext == STEP_HI);
            if (state == IDLE) debug_en <= mode_step;
            if (state == STEP_HI && stateNext == STEP_LO) step_count <= step_count + 16'd1;
            if (stateNext == SCAN && state != SCAN)       snap_valid <= 1'b0;
            else if (state == DRAIN && stateNext == IDLE) snap_valid <= 1'b1;
            // Tag travels alongside the core's read latency so the write lands on the matching word.
            capPipe[0] <= '{vld: (stateNext == SCAN), addr: scanAddrNext};
            for (int i = 1; i < CAPTURE_LAT; i++) capPipe[i] <= capPipe[i-1];
            rd_data <= ({27'd0, rd_addr} < 32'(NUM_ADDR)) ? snapBuf[rd_addr] : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (capPipe[CAPTURE_LAT-1].vld) snapBuf[capPipe[CAPTURE_LAT-1].addr] <= debug_data;
    end

endmodule

// File: tb/tb_debug_scan_host.sv
// Directed bench for debug_scan_host with a registered core model and a read scoreboard.
module tb_debug_scan_host;

    logic        clk = 1'b0;
    logic        rst, mode_step, step_req, snap_req;
    logic        debug_en, debug_step, busy, snap_valid;
    logic [6:0]  debug_addr;
    logic [31:0] debug_data, rd_data;
    logic [4:0]  rd_addr;
    logic [15:0] step_count;

    logic        zero17, snap_req17;
    logic        debug_en17, debug_step17, busy17, snap_valid17;
    logic [6:0]  debug_addr17;
    logic [31:0] debug_data17, rd_data17;
    logic [4:0]  rd_addr17;
    logic [15:0] step_count17;

    int checks = 0;
    int passes = 0;
    logic [31:0] rdq[$];
    int expSteps = 0;

    always #5 clk = ~clk;

    debug_scan_host dut (
        .clk(clk), .rst(rst), .mode_step(mode_step), .step_req(step_req), .snap_req(snap_req),
        .debug_en(debug_en), .debug_step(debug_step), .debug_addr(debug_addr),
        .debug_data(debug_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .snap_valid(snap_valid), .step_count(step_count)
    );

    debug_scan_host #(.NUM_ADDR(17)) dut17 (
        .clk(clk), .rst(rst), .mode_step(zero17), .step_req(zero17), .snap_req(snap_req17),
        .debug_en(debug_en17), .debug_step(debug_step17), .debug_addr(debug_addr17),
        .debug_data(debug_data17), .rd_addr(rd_addr17), .rd_data(rd_data17), .busy(busy17),
        .snap_valid(snap_valid17), .step_count(step_count17)
    );

    // Core model: data registered one edge after the address.
    always_ff @(posedge clk) begin
        debug_data   <= 32'hA000_0000 | {25'd0, debug_addr};
        debug_data17 <= 32'hA000_0000 | {25'd0, debug_addr17};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic doRead(input bit sel17, input logic [4:0] a);
        int lim;
        logic [31:0] exp;
        lim = sel17 ? 17 : 32;
        exp = (int'(a) < lim) ? (32'hA000_0000 | {27'd0, a}) : 32'd0;
        if (sel17) rd_addr17 = a;
        else       rd_addr   = a;
        rdq.push_back(exp);
        tick();
        chk($sformatf("rd%0d_a%0d", lim, a), sel17 ? rd_data17 : rd_data, rdq.pop_front());
    endtask

    // Counts busy cycles and debug_step activity; optionally injects step+snap requests mid-run.
    task automatic measure(input int injectAt, output int n, output int hi, output int rises);
        bit prev;
        prev = 1'b0; n = 0; hi = 0; rises = 0;
        while (busy && n < 300) begin
            if (debug_step) hi++;
            if (debug_step && !prev) rises++;
            prev = debug_step;
            step_req = (n == injectAt);
            snap_req = (n == injectAt);
            n++;
            tick();
        end
        step_req = 1'b0;
        snap_req = 1'b0;
    endtask

    initial begin
        int n, hi, rises, maxAddr;
        rst = 1'b1; mode_step = 1'b0; step_req = 1'b0; snap_req = 1'b0; rd_addr = 5'd0;
        zero17 = 1'b0; snap_req17 = 1'b0; rd_addr17 = 5'd0;
        tick(); tick();
        chk("rst_debug_en", debug_en, 0);
        chk("rst_debug_step", debug_step, 0);
        chk("rst_debug_addr", debug_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_snap_valid", snap_valid, 0);
        chk("rst_step_count", step_count, 0);
        rst = 1'b0;
        tick();

        // Snapshot only
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        measure(-1, n, hi, rises);
        chk("snap_busy_cycles", n, 34);
        chk("snap_no_step", hi, 0);
        chk("snap_valid_after", snap_valid, 1);
        doRead(0, 5'd5);
        doRead(0, 5'd31);
        doRead(0, 5'd0);

        // Step request ignored in free-run mode
        step_req = 1'b1; tick(); step_req = 1'b0;
        chk("free_busy", busy, 0);
        chk("free_debug_step", debug_step, 0);
        tick(); tick();
        chk("free_busy_later", busy, 0);
        chk("free_step_count", step_count, 0);

        // Single step
        mode_step = 1'b1; tick();
        chk("debug_en_loaded", debug_en, 1);
        step_req = 1'b1; tick(); step_req = 1'b0;
        chk("step_first_high", debug_step, 1);
        measure(-1, n, hi, rises);
        expSteps++;
        chk("step_busy_cycles", n, 42);
        chk("step_high_cycles", hi, 4);
        chk("step_pulses", rises, 1);
        chk("step_count_1", step_count, 16'(expSteps));
        chk("step_snap_valid", snap_valid, 1);
        doRead(0, 5'd17);

        // Requests during SCAN are dropped
        step_req = 1'b1; tick(); step_req = 1'b0;
        measure(20, n, hi, rises);
        expSteps++;
        chk("drop_busy_cycles", n, 42);
        chk("drop_pulses", rises, 1);
        chk("drop_step_count", step_count, 16'(expSteps));
        tick(); tick();
        chk("drop_no_rescan", busy, 0);

        // Reset in the middle of a scan
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        n = 0;
        while (debug_addr != 7'd10 && n < 100) begin tick(); n++; end
        chk("reach_addr10", debug_addr, 10);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_debug_addr", debug_addr, 0);
        chk("abort_snap_valid", snap_valid, 0);
        chk("abort_debug_step", debug_step, 0);
        chk("abort_step_count", step_count, 0);
        tick();
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        measure(-1, n, hi, rises);
        chk("resnap_busy_cycles", n, 34);
        chk("resnap_valid", snap_valid, 1);
        doRead(0, 5'd10);

        // Reduced slot count
        snap_req17 = 1'b1; tick(); snap_req17 = 1'b0;
        n = 0; maxAddr = 0;
        while (busy17 && n < 300) begin
            if (int'(debug_addr17) > maxAddr) maxAddr = int'(debug_addr17);
            n++;
            tick();
        end
        chk("n17_busy_cycles", n, 19);
        chk("n17_last_addr", maxAddr, 16);
        chk("n17_snap_valid", snap_valid17, 1);
        doRead(1, 5'd20);
        doRead(1, 5'd16);
        doRead(1, 5'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/debug_scan_host.md
Name: debug_scan_host

Overview:
- Host-side master of the core's debug port: drives debug_en, debug_step and debug_addr, and consumes the core's registered debug_data.
- On request it issues one single-step clock pulse to the core, waits for the pipeline to settle, then sweeps debug_addr across all debug slots.
- Each returned word is captured into a snapshot buffer that the display logic reads through a registered port.
- Sits beside the core at board top level, between the buttons/switches and the display driver.

Parameters:
NUM_ADDR, 32, number of debug slots swept (addresses 0..NUM_ADDR-1), range 1..32
STEP_HIGH, 4, clk cycles debug_step is held high per step
SETTLE, 4, clk cycles debug_step is held low after the pulse, before the scan starts
CAPTURE_LAT, 2, clk edges from the edge that updates debug_addr to the edge that captures the matching debug_data

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
mode_step  in  1  1 = single-step mode (drives debug_en), 0 = free-run
step_req  in  1  one-cycle pulse, already debounced: perform one step then a snapshot
snap_req  in  1  one-cycle pulse: take a snapshot without stepping
debug_en  out  1  to core, registered copy of mode_step
debug_step  out  1  to core, single-step clock
debug_addr  out  7  to core, debug slot select; bits [6:5] always 0
debug_data  in  32  from core, registered by the core one edge after debug_addr
rd_addr  in  5  display read address
rd_data  out  32  snapshot word, registered
busy  out  1  high while state != IDLE
snap_valid  out  1  buffer holds a complete snapshot
step_count  out  16  number of steps issued

Behaviour:
- Reset values: debug_en=0, debug_step=0, debug_addr=0, rd_data=0, busy=0, snap_valid=0, step_count=0, state=IDLE. Buffer contents are not reset.
- Reset mid-operation aborts at the same edge. A partially written buffer stays invalid because snap_valid=0.
- debug_en loads mode_step only in IDLE. A mode change while busy takes effect on return to IDLE.
- States: IDLE, STEP_HI, STEP_LO, SCAN, DRAIN.
- IDLE: step_req && debug_en goes to STEP_HI. Otherwise snap_req goes to SCAN. step_req with debug_en=0 is ignored. If step_req and snap_req arrive together with debug_en=1, the step wins (its scan serves both).
- Requests arriving in any non-IDLE state are dropped, not queued.
- STEP_HI: debug_step=1 for exactly STEP_HIGH cycles, then STEP_LO. step_count increments (mod 2^16) on the STEP_HI to STEP_LO edge.
- STEP_LO: debug_step=0 for SETTLE cycles, then SCAN.
- SCAN entry: snap_valid cleared and debug_addr=0. debug_addr then increments by 1 per cycle up to NUM_ADDR-1. After issuing the last address, go to DRAIN.
- Capture: a delay line of CAPTURE_LAT stages carries {valid, addr}. When the delayed entry is valid, buffer[addr] <= debug_data at that edge.
- DRAIN: lasts CAPTURE_LAT cycles. On exit: last write done, snap_valid=1, debug_addr=0, state=IDLE.
- Timing: busy is high for STEP_HIGH+SETTLE+NUM_ADDR+CAPTURE_LAT cycles for a step, and NUM_ADDR+CAPTURE_LAT cycles for a snap-only request.
- Read port: rd_data <= (rd_addr < NUM_ADDR) ? buffer[rd_addr] : 0, with 1-cycle latency.
- Read port during SCAN: reads are allowed and may return mixed old/new data. A same-cycle read and write of the same entry returns the old value.
- debug_step is driven only from a register, never gated combinationally.

Test Plan:
- Core model returns 32'hA000_0000|addr, registered one edge. After reset, snap_req -> busy=1 for 34 cycles, then snap_valid=1; rd_addr=5 -> rd_data=32'hA000_0005 next cycle; rd_addr=31 -> 32'hA000_001F.
- mode_step=1, wait 1 cycle, step_req -> debug_step high exactly 4 cycles then low; step_count=1; busy for 42 cycles; snap_valid=1 after.
- mode_step=0, step_req -> debug_step stays 0, busy stays 0, step_count=0.
- step_req, then a second step_req and a snap_req during SCAN -> only one debug_step pulse; step_count=1; busy drops after 42 cycles; no second scan starts.
- rst asserted during SCAN when debug_addr=10 -> next cycle busy=0, debug_addr=0, snap_valid=0, debug_step=0; a following snap_req completes normally.
- NUM_ADDR=17 override -> scan ends at debug_addr=16, busy 19 cycles; rd_addr=20 returns 0; rd_addr=16 returns 32'hA000_0010.
